// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response, the
// decode-side instruction handshake, the branch-controller redirect inputs,
// the architectural fetch PC and a debug view of the sequencer state.
//
// Handshake semantics (both channels):
//   imem side  : imem_req is held high with imem_addr stable until the cycle
//                imem_ack is high; imem_rdata is valid only in that cycle. A
//                request is never withdrawn except by reset.
//   decode side: an instruction transfers in a cycle where inst_valid and
//                inst_ready are both high; inst/inst_pc are stable while
//                inst_valid is high and no transfer has happened.
interface fetch_sequencer_if;
    logic        ex_valid;
    logic        jmp_enable;
    logic [29:0] jmp_addr;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic [29:0] pc;
    logic [1:0]  state_dbg;

    // Sequencer side.
    modport master (
        input  ex_valid, jmp_enable, jmp_addr,
        input  imem_ack, imem_rdata,
        input  inst_ready,
        output imem_req, imem_addr,
        output inst_valid, inst, inst_pc,
        output pc, state_dbg
    );

    // Environment side: memory, decode and branch controller.
    modport slave (
        output ex_valid, jmp_enable, jmp_addr,
        output imem_ack, imem_rdata,
        output inst_ready,
        input  imem_req, imem_addr,
        input  inst_valid, inst, inst_pc,
        input  pc, state_dbg
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the multi-cycle RV32I core.
// Owns the word-addressed fetch PC, keeps at most one instruction-memory
// request outstanding, buffers one fetched instruction for decode and applies
// branch redirects, squashing any younger instruction in flight or buffered.
//
// State encoding (visible on state_dbg):
//   0 IDLE  : one cycle after reset, no request
//   1 FETCH : request to pc outstanding
//   2 HOLD  : instruction buffered, waiting for decode
//   3 KILL  : request to a stale address outstanding; its data is dropped
module fetch_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t      state;
    logic [29:0] pc_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [29:0] inst_pc_q;
    logic        req_q;
    // Address presented on imem_addr. It follows pc whenever a new request is
    // launched, but is left untouched on a redirect in FETCH so that a killed
    // request keeps its original address until acknowledged.
    logic [29:0] addr_q;

    logic        redir;

    // A redirect is only meaningful when execute actually retires.
    assign redir = bus.ex_valid & bus.jmp_enable;

    // Single sequencer process: next state plus all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 30'h0;
            req_q     <= 1'b0;
            addr_q    <= 30'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    if (redir) begin
                        pc_q   <= bus.jmp_addr;
                        addr_q <= bus.jmp_addr;
                    end else begin
                        addr_q <= pc_q;
                    end
                end

                FETCH: begin
                    if (bus.imem_ack && !redir) begin
                        inst_q    <= bus.imem_rdata;
                        inst_pc_q <= pc_q;
                        valid_q   <= 1'b1;
                        pc_q      <= pc_q + 30'd1;
                        req_q     <= 1'b0;
                        state     <= HOLD;
                    end else if (bus.imem_ack && redir) begin
                        // Response belongs to the wrong path: drop it and
                        // immediately request the branch target.
                        pc_q   <= bus.jmp_addr;
                        addr_q <= bus.jmp_addr;
                    end else if (redir) begin
                        // Request still pending: cannot withdraw it, so wait
                        // for its ack in KILL with addr_q holding the old PC.
                        pc_q  <= bus.jmp_addr;
                        state <= KILL;
                    end
                end

                HOLD: begin
                    if (redir) begin
                        valid_q <= 1'b0;
                        pc_q    <= bus.jmp_addr;
                        addr_q  <= bus.jmp_addr;
                        req_q   <= 1'b1;
                        state   <= FETCH;
                    end else if (bus.inst_ready) begin
                        // pc was already advanced when this word was captured.
                        valid_q <= 1'b0;
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        state   <= FETCH;
                    end
                end

                KILL: begin
                    if (redir) begin
                        pc_q <= bus.jmp_addr;
                    end
                    if (bus.imem_ack) begin
                        // Stale data discarded; launch the newest target.
                        state  <= FETCH;
                        addr_q <= redir ? bus.jmp_addr : pc_q;
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs: all registered except inst_valid, which is masked by a
    // same-cycle redirect so a squashed instruction can never transfer.
    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q & ~redir;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.pc         = pc_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: reset, streaming, backpressure,
// squash in HOLD, redirects around a slow fetch, and PC wrap-around.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();
    fetch_sequencer_if wbus ();

    fetch_sequencer #(.RESET_PC(30'h100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_sequencer #(.RESET_PC(30'h3FFF_FFFF)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus.master)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_KILL  = 2'd3;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ex_valid    = 1'b0;
        bus.jmp_enable  = 1'b0;
        bus.jmp_addr    = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        wbus.ex_valid   = 1'b0;
        wbus.jmp_enable = 1'b0;
        wbus.jmp_addr   = '0;
        wbus.imem_ack   = 1'b0;
        wbus.imem_rdata = '0;
        wbus.inst_ready = 1'b0;
    endtask

    // Leaves both DUTs in their first FETCH cycle.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    // Called at the start of a FETCH cycle for addr. Serves the request after
    // `waits` idle cycles, then checks the buffered word in the HOLD cycle,
    // where inst_ready is driven to ready_in.
    task automatic fetch_one(input int waits, input logic [31:0] data,
                             input logic [29:0] addr, input logic ready_in);
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack = 1'b0;
            #1;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr) begin
                errors++;
                $display("FAIL fetch_wait req=%b addr=%h expected req=1 addr=%h",
                         bus.imem_req, bus.imem_addr, addr);
            end
            next_cycle();
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr) begin
            errors++;
            $display("FAIL fetch_ack req=%b addr=%h expected req=1 addr=%h",
                     bus.imem_req, bus.imem_addr, addr);
        end
        next_cycle();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = ready_in;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== data || bus.inst_pc !== addr
            || bus.imem_req !== 1'b0 || bus.state_dbg !== S_HOLD) begin
            errors++;
            $display("FAIL fetch_hold valid=%b inst=%h pc=%h req=%b st=%0d expected valid=1 inst=%h pc=%h req=0 st=2",
                     bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req, bus.state_dbg, data, addr);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (bus.imem_req !== 1'b0 || bus.imem_addr !== 30'h0 || bus.inst_valid !== 1'b0
                || bus.inst !== 32'h0 || bus.inst_pc !== 30'h0 || bus.pc !== 30'h100
                || bus.state_dbg !== S_IDLE) begin
                errors++;
                $display("FAIL reset_values req=%b addr=%h valid=%b inst=%h ipc=%h pc=%h st=%0d expected 0/0/0/0/0/100/0",
                         bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc,
                         bus.pc, bus.state_dbg);
            end
        end
        checks++;
        if (wbus.pc !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL reset_wrap_pc got=%h expected=3fffffff", wbus.pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL reset_cycle0 req=%b st=%0d expected req=0 st=0",
                     bus.imem_req, bus.state_dbg);
        end
        next_cycle();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h100) begin
            errors++;
            $display("FAIL reset_first_req req=%b addr=%h expected req=1 addr=100",
                     bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_streaming();
        fetch_one(1, 32'h0000_0013, 30'h100, 1'b1);
        next_cycle();
        fetch_one(1, 32'h0010_0093, 30'h101, 1'b1);
        next_cycle();
        fetch_one(1, 32'h0020_0113, 30'h102, 1'b0);
        checks++;
        if (bus.pc !== 30'h103) begin
            errors++;
            $display("FAIL stream_pc got=%h expected=103", bus.pc);
        end
    endtask

    // Continues from the HOLD cycle left by test_streaming (inst_ready=0).
    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0020_0113
                || bus.inst_pc !== 30'h102 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b inst=%h ipc=%h req=%b expected 1/00200113/102/0",
                         i, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req);
            end
            if (i < 4) next_cycle();
        end
        bus.inst_ready = 1'b1;
        next_cycle();
        bus.inst_ready = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h103 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release req=%b addr=%h valid=%b expected req=1 addr=103 valid=0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid);
        end
    endtask

    task automatic test_squash_hold();
        do_reset();
        fetch_one(0, 32'h0000_0013, 30'h100, 1'b1);
        next_cycle();
        fetch_one(0, 32'h0010_0093, 30'h101, 1'b0);
        // jmp_enable without ex_valid must be ignored.
        bus.jmp_enable = 1'b1;
        bus.jmp_addr   = 30'h250;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL squash_ignored_jmp valid=%b expected=1", bus.inst_valid);
        end
        bus.ex_valid   = 1'b1;
        bus.jmp_addr   = 30'h200;
        bus.inst_ready = 1'b1;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_mask valid=%b expected=0", bus.inst_valid);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (bus.state_dbg !== S_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h200
            || bus.inst_valid !== 1'b0 || bus.pc !== 30'h200) begin
            errors++;
            $display("FAIL squash_redirect st=%0d req=%b addr=%h valid=%b pc=%h expected 1/1/200/0/200",
                     bus.state_dbg, bus.imem_req, bus.imem_addr, bus.inst_valid, bus.pc);
        end
    endtask

    task automatic test_redirect_fetch();
        do_reset();
        fetch_one(0, 32'h0000_0013, 30'h100, 1'b1);
        next_cycle();
        fetch_one(0, 32'h0010_0093, 30'h101, 1'b1);
        next_cycle();
        // FETCH of 0x102 with no ack; redirect to 0x200.
        bus.inst_ready = 1'b0;
        bus.ex_valid   = 1'b1;
        bus.jmp_enable = 1'b1;
        bus.jmp_addr   = 30'h200;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h102) begin
            errors++;
            $display("FAIL kill_start req=%b addr=%h expected req=1 addr=102",
                     bus.imem_req, bus.imem_addr);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (bus.state_dbg !== S_KILL || bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h102
            || bus.pc !== 30'h200) begin
            errors++;
            $display("FAIL kill_enter st=%0d req=%b addr=%h pc=%h expected 3/1/102/200",
                     bus.state_dbg, bus.imem_req, bus.imem_addr, bus.pc);
        end
        next_cycle();
        // Second redirect while still in KILL.
        bus.ex_valid   = 1'b1;
        bus.jmp_enable = 1'b1;
        bus.jmp_addr   = 30'h300;
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (bus.state_dbg !== S_KILL || bus.imem_addr !== 30'h102 || bus.pc !== 30'h300) begin
            errors++;
            $display("FAIL kill_redir2 st=%0d addr=%h pc=%h expected 3/102/300",
                     bus.state_dbg, bus.imem_addr, bus.pc);
        end
        // Killed ack arrives with poison data.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (bus.state_dbg !== S_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h300
            || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0010_0093) begin
            errors++;
            $display("FAIL kill_ack st=%0d req=%b addr=%h valid=%b inst=%h expected 1/1/300/0/00100093",
                     bus.state_dbg, bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst);
        end
        // Redirect coincident with an ack in FETCH.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        bus.ex_valid   = 1'b1;
        bus.jmp_enable = 1'b1;
        bus.jmp_addr   = 30'h400;
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (bus.state_dbg !== S_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h400
            || bus.pc !== 30'h400 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0010_0093) begin
            errors++;
            $display("FAIL ack_redir st=%0d req=%b addr=%h pc=%h valid=%b inst=%h expected 1/1/400/400/0/00100093",
                     bus.state_dbg, bus.imem_req, bus.imem_addr, bus.pc, bus.inst_valid, bus.inst);
        end
        fetch_one(0, 32'h0000_0513, 30'h400, 1'b1);
        checks++;
        if (bus.pc !== 30'h401) begin
            errors++;
            $display("FAIL ack_redir_pc got=%h expected=401", bus.pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wbus.imem_ack   = 1'b1;
        wbus.imem_rdata = 32'h0000_0013;
        #1;
        checks++;
        if (wbus.imem_req !== 1'b1 || wbus.imem_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_req req=%b addr=%h expected req=1 addr=3fffffff",
                     wbus.imem_req, wbus.imem_addr);
        end
        next_cycle();
        wbus.imem_ack   = 1'b0;
        wbus.inst_ready = 1'b1;
        #1;
        checks++;
        if (wbus.inst_valid !== 1'b1 || wbus.inst_pc !== 30'h3FFF_FFFF || wbus.pc !== 30'h0) begin
            errors++;
            $display("FAIL wrap_pc valid=%b ipc=%h pc=%h expected 1/3fffffff/0",
                     wbus.inst_valid, wbus.inst_pc, wbus.pc);
        end
        next_cycle();
        wbus.inst_ready = 1'b0;
        #1;
        checks++;
        if (wbus.imem_req !== 1'b1 || wbus.imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL wrap_next req=%b addr=%h expected req=1 addr=0",
                     wbus.imem_req, wbus.imem_addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_squash_hold();
        test_redirect_fetch();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
